exec_clock_controller: RTL and testbench

Run/stop/single-step controller that produces the processor's `clk_operating` one-cycle execution enable from the board clock.
- Programmable prescaler sets the free-run rate.
- Sequences the enable according to operator requests and stops permanently when the pipeline reports a halt.
- Sits between board-level controls and the 32-bit MIPS pipeline core; replaces direct use of the bare counter as the enable source.

---
 rtl/exec_clk_pkg.sv | 17 +
 rtl/exec_clock_controller_prescaler_counter.sv | 43 ++++
 rtl/exec_clock_controller.sv | 136 +++++++++++++
 tb/tb_exec_clock_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/exec_clk_pkg.sv
// Shared definitions for the execution clock controller.
//   - exec_state_e : controller state encoding (2 bits)
//   - DefCntWidth  : default prescaler / period width
//   - DefCycWidth  : default executed-cycle counter width
package exec_clk_pkg;

   localparam int unsigned DefCntWidth = 24;
   localparam int unsigned DefCycWidth = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } exec_state_e;

endpackage

// File: rtl/exec_clock_controller_prescaler_counter.sv
// Free-running prescaler for the execution clock controller.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   clr      : synchronous clear, dominates en
//   en       : count enable
//   terminal : terminal count compared against the current count
//   tick     : high while count == terminal
module prescaler_counter #(
   parameter int unsigned CNT_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic [CNT_WIDTH-1:0] terminal,
   output logic                 tick
);

   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + CntOne;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = (count_q == terminal);

endmodule

// File: rtl/exec_clock_controller.sv
// Run/stop/single-step controller producing the one-cycle execution enable
// (clk_operating) for the pipeline core.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   run/stop/step : single-cycle operator requests
//   period        : prescaler terminal count, latched on entry to RUN
//   halt_in       : pipeline halt, forces HALTED until reset
//   clk_operating : registered one-cycle execution enable
//   busy, halted  : decoded from the registered state
//   cycle_count   : saturating count of issued enables
module exec_clock_controller
   import exec_clk_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = DefCntWidth,
   parameter int unsigned CYC_WIDTH = DefCycWidth
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 stop,
   input  logic                 step,
   input  logic [CNT_WIDTH-1:0] period,
   input  logic                 halt_in,
   output logic                 clk_operating,
   output logic                 busy,
   output logic                 halted,
   output logic [CYC_WIDTH-1:0] cycle_count
);

   localparam logic [CYC_WIDTH-1:0] CycOne = CYC_WIDTH'(1);

   exec_state_e          state_q, state_d;
   logic [CNT_WIDTH-1:0] period_q, period_d;
   logic                 pulse_q, pulse_d;
   logic [CYC_WIDTH-1:0] cycle_count_q, cycle_count_d;
   logic                 presc_clr, presc_en, presc_tick;

   prescaler_counter #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .clr     (presc_clr),
      .en      (presc_en),
      .terminal(period_q),
      .tick    (presc_tick)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; priority halt_in > stop > run > step
   always_comb begin
      state_d = state_q;
      if (halt_in) begin
         state_d = ST_HALTED;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!stop) begin
                  if (run) begin
                     state_d = ST_RUN;
                  end else if (step) begin
                     state_d = ST_STEP;
                  end
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_d = ST_IDLE;
               end
            end
            ST_STEP:   state_d = ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Output and datapath next-state logic
   always_comb begin
      busy          = (state_q == ST_RUN) || (state_q == ST_STEP);
      halted        = (state_q == ST_HALTED);
      pulse_d       = 1'b0;
      period_d      = period_q;
      presc_en      = (state_q == ST_RUN);
      // Prescaler sits at zero outside RUN so every RUN entry starts from zero.
      presc_clr     = (state_q != ST_RUN) || presc_tick || stop || halt_in;
      cycle_count_d = cycle_count_q;

      if (!halt_in) begin
         case (state_q)
            ST_IDLE: begin
               if (!stop && run) begin
                  period_d = period;
               end
            end
            ST_RUN: begin
               pulse_d = presc_tick && !stop;
            end
            ST_STEP: begin
               pulse_d = 1'b1;
            end
            default: begin
               pulse_d = 1'b0;
            end
         endcase
      end

      if (pulse_d && (cycle_count_q != '1)) begin
         cycle_count_d = cycle_count_q + CycOne;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_q      <= '0;
         pulse_q       <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         period_q      <= period_d;
         pulse_q       <= pulse_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign clk_operating = pulse_q;
   assign cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_exec_clock_controller.sv
module tb_exec_clock_controller;

   logic        clk = 1'b0;
   logic        rst, run, stop, step, halt_in;
   logic [23:0] period;
   logic        clk_operating, busy, halted;
   logic [31:0] cycle_count;

   // Narrow-counter instance for saturation
   logic        s_run, s_stop, s_step, s_halt;
   logic [23:0] s_period;
   logic        s_clk_operating, s_busy, s_halted;
   logic [3:0]  s_cycle_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exec_clock_controller dut (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .stop         (stop),
      .step         (step),
      .period       (period),
      .halt_in      (halt_in),
      .clk_operating(clk_operating),
      .busy         (busy),
      .halted       (halted),
      .cycle_count  (cycle_count)
   );

   exec_clock_controller #(
      .CNT_WIDTH(24),
      .CYC_WIDTH(4)
   ) dut_sat (
      .clk          (clk),
      .rst          (rst),
      .run          (s_run),
      .stop         (s_stop),
      .step         (s_step),
      .period       (s_period),
      .halt_in      (s_halt),
      .clk_operating(s_clk_operating),
      .busy         (s_busy),
      .halted       (s_halted),
      .cycle_count  (s_cycle_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0; stop = 1'b0; step = 1'b0; halt_in = 1'b0;
      s_run = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; stop = 1'b0; step = 1'b0; halt_in = 1'b0; period = '0;
      s_run = 1'b0; s_stop = 1'b0; s_step = 1'b0; s_halt = 1'b0; s_period = '0;

      // Reset then idle
      do_reset();
      for (int c = 0; c < 20; c++) begin
         check_eq($sformatf("idle clk c%0d", c), 32'(clk_operating), 32'd0);
         check_eq($sformatf("idle busy c%0d", c), 32'(busy), 32'd0);
         check_eq($sformatf("idle halted c%0d", c), 32'(halted), 32'd0);
         check_eq($sformatf("idle count c%0d", c), cycle_count, 32'd0);
         cyc();
      end

      // Free run, period 3; period change mid-run must not matter
      do_reset();
      period = 24'd3;
      run    = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         cyc();
         run    = 1'b0;
         period = (c >= 3) ? 24'd7 : 24'd3;
         stop   = (c == 15);
         check_eq($sformatf("p3 clk c%0d", c), 32'(clk_operating),
                  32'(c == 5 || c == 9 || c == 13));
         check_eq($sformatf("p3 busy c%0d", c), 32'(busy), 32'(c <= 15));
      end
      stop = 1'b0;
      check_eq("p3 count", cycle_count, 32'd3);

      // period 0: continuous enable, stop after ten pulses
      do_reset();
      period = 24'd0;
      run    = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         run  = 1'b0;
         stop = (c == 11);
         check_eq($sformatf("p0 clk c%0d", c), 32'(clk_operating), 32'(c >= 2 && c <= 11));
      end
      stop = 1'b0;
      check_eq("p0 count", cycle_count, 32'd10);
      check_eq("p0 busy", 32'(busy), 32'd0);

      // Single steps; the request at cycle 11 arrives while in STEP
      do_reset();
      for (int c = 0; c <= 14; c++) begin
         check_eq($sformatf("step clk c%0d", c), 32'(clk_operating),
                  32'(c == 2 || c == 7 || c == 12));
         check_eq($sformatf("step busy c%0d", c), 32'(busy), 32'(c == 1 || c == 6 || c == 11));
         step = (c == 0 || c == 5 || c == 10 || c == 11);
         cyc();
      end
      step = 1'b0;
      check_eq("step count", cycle_count, 32'd3);

      // run+step together -> RUN; halt on the edge a pulse is due
      do_reset();
      period = 24'd2;
      run    = 1'b1;
      step   = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         run     = (c == 8);
         step    = (c == 9);
         stop    = (c == 10);
         halt_in = (c == 6);
         check_eq($sformatf("halt clk c%0d", c), 32'(clk_operating), 32'(c == 4));
         check_eq($sformatf("halt halted c%0d", c), 32'(halted), 32'(c >= 7));
         check_eq($sformatf("halt busy c%0d", c), 32'(busy), 32'(c <= 6));
      end
      run = 1'b0; step = 1'b0; stop = 1'b0; halt_in = 1'b0;
      check_eq("halt count", cycle_count, 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_eq("halt rst halted", 32'(halted), 32'd0);
      check_eq("halt rst busy", 32'(busy), 32'd0);
      check_eq("halt rst count", cycle_count, 32'd0);

      // Saturation on the 4-bit counter, then reset mid-RUN
      do_reset();
      s_period = 24'd0;
      s_run    = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         cyc();
         s_run = 1'b0;
         check_eq($sformatf("sat count c%0d", c), 32'(s_cycle_count),
                  (c < 2) ? 32'd0 : ((c - 1 > 15) ? 32'd15 : 32'(c - 1)));
         check_eq($sformatf("sat clk c%0d", c), 32'(s_clk_operating), 32'(c >= 2));
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_eq("midrst clk", 32'(s_clk_operating), 32'd0);
      check_eq("midrst busy", 32'(s_busy), 32'd0);
      check_eq("midrst halted", 32'(s_halted), 32'd0);
      check_eq("midrst count", 32'(s_cycle_count), 32'd0);
      cyc();
      check_eq("midrst idle clk", 32'(s_clk_operating), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
